// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one float adder between two requesters
module adder_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_stb,
  output logic             req0_ack,
  output logic [WIDTH-1:0] req0_z,
  output logic             req0_z_stb,
  input  logic             req0_z_ack,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_stb,
  output logic             req1_ack,
  output logic [WIDTH-1:0] req1_z,
  output logic             req1_z_stb,
  input  logic             req1_z_ack,
  output logic [WIDTH-1:0] add_a,
  output logic             add_a_stb,
  input  logic             add_a_ack,
  output logic [WIDTH-1:0] add_b,
  output logic             add_b_stb,
  input  logic             add_b_ack,
  input  logic [WIDTH-1:0] add_z,
  input  logic             add_z_stb,
  output logic             add_z_ack,
  output logic             grant,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_A   = 3'd1,
    SEND_B   = 3'd2,
    WAIT_Z   = 3'd3,
    RETURN_Z = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last_grant;
  logic   sel;
  logic   take;
  logic   z_ack_sel;

  // When both requesters are waiting, the one not served last time wins.
  always_comb begin
    if (req0_stb && req1_stb) begin
      sel = ~last_grant;
    end else begin
      sel = req1_stb;
    end
  end

  assign take      = (state == IDLE) && (req0_stb || req1_stb) && !rst;
  assign z_ack_sel = grant ? req1_z_ack : req0_z_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (take)      state_nxt = SEND_A;
      SEND_A:   if (add_a_ack) state_nxt = SEND_B;
      SEND_B:   if (add_b_ack) state_nxt = WAIT_Z;
      WAIT_Z:   if (add_z_stb) state_nxt = RETURN_Z;
      RETURN_Z: if (z_ack_sel) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ack   = take && !sel;
    req1_ack   = take && sel;
    add_a_stb  = (state == SEND_A);
    add_b_stb  = (state == SEND_B);
    add_z_ack  = (state == WAIT_Z);
    req0_z_stb = (state == RETURN_Z) && !grant;
    req1_z_stb = (state == RETURN_Z) && grant;
    busy       = (state != IDLE);
  end

  // Results stay in the per-requester register until that requester's next result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_a      <= '0;
      add_b      <= '0;
      req0_z     <= '0;
      req1_z     <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (take) begin
        add_a <= sel ? req1_a : req0_a;
        add_b <= sel ? req1_b : req0_b;
        grant <= sel;
      end
      if ((state == WAIT_Z) && add_z_stb) begin
        if (grant) begin
          req1_z <= add_z;
        end else begin
          req0_z <= add_z;
        end
      end
      if ((state == RETURN_Z) && z_ack_sel) begin
        last_grant <= grant;
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - self-checking bench for adder_arbiter with a behavioural adder
module tb_adder_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] req0_a, req0_b, req0_z, req1_a, req1_b, req1_z;
  logic        req0_stb, req0_ack, req0_z_stb, req0_z_ack;
  logic        req1_stb, req1_ack, req1_z_stb, req1_z_ack;
  logic [31:0] add_a, add_b, add_z;
  logic        add_a_stb, add_a_ack, add_b_stb, add_b_ack, add_z_stb, add_z_ack;
  logic        grant, busy;

  adder_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_a(req0_a), .req0_b(req0_b), .req0_stb(req0_stb), .req0_ack(req0_ack),
    .req0_z(req0_z), .req0_z_stb(req0_z_stb), .req0_z_ack(req0_z_ack),
    .req1_a(req1_a), .req1_b(req1_b), .req1_stb(req1_stb), .req1_ack(req1_ack),
    .req1_z(req1_z), .req1_z_stb(req1_z_stb), .req1_z_ack(req1_z_ack),
    .add_a(add_a), .add_a_stb(add_a_stb), .add_a_ack(add_a_ack),
    .add_b(add_b), .add_b_stb(add_b_stb), .add_b_ack(add_b_ack),
    .add_z(add_z), .add_z_stb(add_z_stb), .add_z_ack(add_z_ack),
    .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Known IEEE-754 sums; anything else gets an arbitrary but deterministic mix.
  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h42490000 && b == 32'h42200000) return 32'h42B48000;
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A0000;
  endfunction

  int          a_delay = 0;
  int          z_lat = 2;
  logic [1:0]  ms;
  int          a_cnt, z_cnt;
  logic [31:0] ma, mb;

  assign add_a_ack = (ms == 2'd0) && (a_cnt >= a_delay);
  assign add_b_ack = (ms == 2'd1);
  assign add_z_stb = (ms == 2'd2) && (z_cnt >= z_lat);
  assign add_z     = add_z_stb ? model_add(ma, mb) : 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ms <= 2'd0; a_cnt <= 0; z_cnt <= 0; ma <= '0; mb <= '0;
    end else begin
      case (ms)
        2'd0: if (add_a_stb) begin
          if (add_a_ack) begin ma <= add_a; ms <= 2'd1; a_cnt <= 0; end
          else a_cnt <= a_cnt + 1;
        end
        2'd1: if (add_b_stb) begin mb <= add_b; ms <= 2'd2; z_cnt <= 0; end
        default: if (add_z_stb && add_z_ack) ms <= 2'd0; else z_cnt <= z_cnt + 1;
      endcase
    end
  end

  logic [31:0] exp0[$];
  logic [31:0] exp1[$];
  int          acc_log[$];
  int          z0_hs = 0, z1_hs = 0, a_stb_cyc = 0, idle_gap = 0;
  bit          win = 0;
  bit          a_pend = 0;
  logic [31:0] prev_a;

  always @(negedge clk) begin
    if (rst) begin
      a_pend = 0;
    end else begin
      if (req0_z_stb && req0_z_ack) begin
        z0_hs++;
        chk("grant_on_z0", {31'd0, grant}, 32'd0);
        if (exp0.size() == 0) chk("unexpected_z0", 32'd1, 32'd0);
        else chk("req0_z", req0_z, exp0.pop_front());
      end
      if (req1_z_stb && req1_z_ack) begin
        z1_hs++;
        chk("grant_on_z1", {31'd0, grant}, 32'd1);
        if (exp1.size() == 0) chk("unexpected_z1", 32'd1, 32'd0);
        else chk("req1_z", req1_z, exp1.pop_front());
      end
      if (add_a_stb) a_stb_cyc++;
      if (a_pend) begin
        chk("add_a_stb_hold", {31'd0, add_a_stb}, 32'd1);
        chk("add_a_stable", add_a, prev_a);
      end
      a_pend = add_a_stb && !add_a_ack;
      prev_a = add_a;
      if (add_b_stb) chk("b_with_a", {31'd0, add_a_stb}, 32'd0);
      if (req0_ack || req1_ack) chk("ack_while_busy", {31'd0, busy}, 32'd0);
      if (win && !busy && acc_log.size() >= 1 && acc_log.size() <= 3) idle_gap++;
      if (req0_ack && req0_stb) acc_log.push_back(0);
      if (req1_ack && req1_stb) acc_log.push_back(1);
    end
  end

  task automatic send(input int n, input logic [31:0] a, input logic [31:0] b, input logic [31:0] z);
    int t;
    @(posedge clk); #1;
    if (n == 0) begin req0_a = a; req0_b = b; req0_stb = 1'b1; end
    else begin req1_a = a; req1_b = b; req1_stb = 1'b1; end
    t = 0;
    do begin @(negedge clk); t++; end while (!((n == 0) ? req0_ack : req1_ack) && t < 600);
    chk("ack_seen", {31'd0, t < 600}, 32'd1);
    if (t < 600) begin
      if (n == 0) exp0.push_back(z); else exp1.push_back(z);
    end
    @(posedge clk); #1;
    if (n == 0) req0_stb = 1'b0; else req1_stb = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    do begin @(negedge clk); t++; end
    while ((exp0.size() != 0 || exp1.size() != 0 || busy) && t < 2000);
    chk("done_in_time", {31'd0, t < 2000}, 32'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  typedef struct {
    int          n;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    int          dly;
  } vec_t;

  initial begin
    vec_t        vecs[6];
    logic [31:0] ra, rb, last0;
    int          stall_ok;

    vecs[0] = '{0, 32'h42490000, 32'h42200000, 32'h42B48000, 0};
    vecs[1] = '{1, 32'h3F800000, 32'h40000000, 32'h40400000, 0};
    vecs[2] = '{0, 32'h3F800000, 32'h40000000, 32'h40400000, 7};
    for (int i = 3; i < 6; i++) begin
      ra = $urandom; rb = $urandom;
      vecs[i] = '{i % 2, ra, rb, model_add(ra, rb), i - 2};
    end

    rst = 1'b1;
    req0_a = '0; req0_b = '0; req0_stb = 1'b0; req0_z_ack = 1'b1;
    req1_a = '0; req1_b = '0; req1_stb = 1'b0; req1_z_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_grant", {31'd0, grant}, 32'd0);
    chk("rst_strobes", {25'd0, add_a_stb, add_b_stb, add_z_ack, req0_ack, req1_ack,
                        req0_z_stb, req1_z_stb}, 32'd0);
    chk("rst_add_a", add_a, 32'd0);
    chk("rst_req0_z", req0_z, 32'd0);
    chk("rst_req1_z", req1_z, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Both requesters strobe in the same cycle right after reset: req0 first.
    acc_log.delete();
    fork
      send(0, 32'h3F800000, 32'h40000000, 32'h40400000);
      send(1, 32'h42490000, 32'h42200000, 32'h42B48000);
    join
    wait_done();
    chk("simul_count", acc_log.size(), 32'd2);
    if (acc_log.size() == 2) begin
      chk("simul_first", acc_log[0], 32'd0);
      chk("simul_second", acc_log[1], 32'd1);
    end

    // Table of single operations, with per-entry adder input_a ack delay.
    last0 = '0;
    for (int i = 0; i < 6; i++) begin
      z0_hs = 0; z1_hs = 0; a_stb_cyc = 0; a_delay = vecs[i].dly;
      send(vecs[i].n, vecs[i].a, vecs[i].b, vecs[i].z);
      wait_done();
      chk("z0_pulses", z0_hs, (vecs[i].n == 0) ? 32'd1 : 32'd0);
      chk("z1_pulses", z1_hs, (vecs[i].n == 1) ? 32'd1 : 32'd0);
      chk("a_stb_cycles", a_stb_cyc, vecs[i].dly + 1);
      if (vecs[i].n == 0) last0 = vecs[i].z;
    end
    a_delay = 0;
    chk("req0_z_holds", req0_z, last0);

    // req1 withholds z_ack while req0 waits.
    acc_log.delete();
    req1_z_ack = 1'b0;
    send(1, 32'h11112222, 32'h33334444, model_add(32'h11112222, 32'h33334444));
    fork
      send(0, 32'h3F800000, 32'h40000000, 32'h40400000);
      begin
        int t = 0;
        do begin @(negedge clk); t++; end while (!req1_z_stb && t < 500);
        chk("stall_reached", {31'd0, req1_z_stb}, 32'd1);
        stall_ok = 0;
        repeat (50) begin
          @(negedge clk);
          if (req1_z_stb && !req0_ack && busy) stall_ok++;
        end
        chk("stall_hold", stall_ok, 32'd50);
        @(posedge clk); #1; req1_z_ack = 1'b1;
      end
    join
    wait_done();
    chk("stall_count", acc_log.size(), 32'd2);
    if (acc_log.size() == 2) chk("stall_next_req0", acc_log[1], 32'd0);

    // Reset during WAIT_Z, then a clean rerun on req1.
    z_lat = 20;
    send(0, 32'h3F800000, 32'h40000000, 32'h40400000);
    begin
      int t = 0;
      do begin @(negedge clk); t++; end while (!add_z_ack && t < 100);
      chk("reached_wait_z", {31'd0, add_z_ack}, 32'd1);
    end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_strobes", {25'd0, add_a_stb, add_b_stb, add_z_ack, req0_ack, req1_ack,
                           req0_z_stb, req1_z_stb}, 32'd0);
    chk("midrst_req0_z", req0_z, 32'd0);
    exp0.delete();
    @(posedge clk); #1; rst = 1'b0;
    z_lat = 2;
    send(1, 32'h3F800000, 32'h40000000, 32'h40400000);
    wait_done();
    chk("post_rst_req1_z", req1_z, 32'h40400000);

    // Both held for four operations after reset: strict alternation, 1-cycle idle gaps.
    pulse_reset();
    acc_log.delete();
    idle_gap = 0;
    win = 1;
    fork
      begin
        send(0, 32'h01020304, 32'h05060708, model_add(32'h01020304, 32'h05060708));
        send(0, 32'h0A0B0C0D, 32'h01010101, model_add(32'h0A0B0C0D, 32'h01010101));
      end
      begin
        send(1, 32'hDEADBEEF, 32'h12345678, model_add(32'hDEADBEEF, 32'h12345678));
        send(1, 32'hCAFEF00D, 32'h87654321, model_add(32'hCAFEF00D, 32'h87654321));
      end
    join
    wait_done();
    win = 0;
    chk("alt_count", acc_log.size(), 32'd4);
    if (acc_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("alt_grant", acc_log[i], i % 2);
    end
    chk("alt_idle_gaps", idle_gap, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
